// File: rtl/sgmii_mdio_pkg.sv
// Shared encodings for the clause-22 MDIO management initiator.
package sgmii_mdio_pkg;

  // Which part of the frame is currently on the wire.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4
  } state_e;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int DATA_BITS = 16;

endpackage

// File: rtl/sgmii_mdio_clkgen.sv
// MDC generator: each bit is CLK_DIV cycles low then CLK_DIV cycles high.
// The strobes are high for the single cycle before the edge on which mdc
// falls (bit start) or rises (sample point). The first event of a frame is
// a fall, so mdc stays low through the first bit's low phase.
module sgmii_mdio_clkgen
  import sgmii_mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic i_en,
  input  logic i_stop,
  output logic o_mdc,
  output logic o_fall_stb,
  output logic o_rise_stb
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_hi;
  logic       r_mdc;
  logic       w_tick;

  assign w_tick     = i_en && (r_div == 8'd0);
  assign o_fall_stb = w_tick && !r_hi;
  assign o_rise_stb = w_tick && r_hi;
  assign o_mdc      = r_mdc;

  // Divider and half-period phase; parked at zero whenever no frame runs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || !i_en || i_stop) begin
      r_div <= 8'd0;
      r_hi  <= 1'b0;
      r_mdc <= 1'b0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
      if (w_tick) begin
        r_mdc <= r_hi;
        r_hi  <= !r_hi;
      end
    end
  end

endmodule

// File: rtl/sgmii_mdio_master.sv
// Clause-22 MDIO initiator: serialises preamble, header, turnaround and data
// onto MDIO, and for reads captures the PHY's turnaround and data bits.
// Bits start on mdc fall strobes and are sampled on mdc rise strobes.
module sgmii_mdio_master
  import sgmii_mdio_pkg::*;
#(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        op_read,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  state_e      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_mdio_o, w_mdio_o_nxt;
  logic        r_mdio_t, w_mdio_t_nxt;
  logic        w_accept;
  logic        w_fall_stb, w_rise_stb;
  logic [3:0]  w_hdr_idx, w_dat_idx;

  logic        r_op_read;
  logic [13:0] r_hdr;
  logic [15:0] r_wdata;
  logic [15:0] r_rshift;
  logic [15:0] r_rd_data;
  logic        r_rd_err;

  sgmii_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .i_en       (r_busy),
    .i_stop     (w_done_nxt),
    .o_mdc      (mdc),
    .o_fall_stb (w_fall_stb),
    .o_rise_stb (w_rise_stb)
  );

  // Next-state logic: accept a command when idle, advance one bit per fall strobe.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    if (!r_busy) begin
      if (start) begin
        w_accept   = 1'b1;
        w_busy_nxt = 1'b1;
      end
    end else if (w_fall_stb) begin
      w_cnt_nxt = r_cnt + 6'd1;
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
          w_cnt_nxt   = 6'd0;
        end
        S_PRE: if (r_cnt == PRE_LAST) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 6'd0;
        end
        S_HDR: if (r_cnt == HDR_LAST) begin
          w_state_nxt = S_TA;
          w_cnt_nxt   = 6'd0;
        end
        S_TA: if (r_cnt == 6'd1) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = 6'd0;
        end
        S_DATA: if (r_cnt == DATA_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  // Pad drive for the bit that starts on this fall strobe; released when idle.
  always_comb begin
    w_mdio_o_nxt = r_mdio_o;
    w_mdio_t_nxt = r_mdio_t;
    w_hdr_idx    = 4'(HDR_BITS - 1) - w_cnt_nxt[3:0];
    w_dat_idx    = 4'(DATA_BITS - 1) - w_cnt_nxt[3:0];
    if (w_fall_stb) begin
      unique case (w_state_nxt)
        S_PRE: begin
          w_mdio_o_nxt = 1'b1;
          w_mdio_t_nxt = 1'b0;
        end
        S_HDR: begin
          w_mdio_o_nxt = r_hdr[w_hdr_idx];
          w_mdio_t_nxt = 1'b0;
        end
        S_TA: begin
          w_mdio_o_nxt = r_op_read ? 1'b1 : (w_cnt_nxt[0] ? TA_WRITE[0] : TA_WRITE[1]);
          w_mdio_t_nxt = r_op_read;
        end
        S_DATA: begin
          w_mdio_o_nxt = r_op_read ? 1'b1 : r_wdata[w_dat_idx];
          w_mdio_t_nxt = r_op_read;
        end
        default: begin
          w_mdio_o_nxt = 1'b1;
          w_mdio_t_nxt = 1'b1;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments everywhere in clocked logic, so every
    // flop updates from values sampled before the edge.
    if (!ARESETN) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mdio_o <= 1'b1;
      r_mdio_t <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_mdio_o <= w_mdio_o_nxt;
      r_mdio_t <= w_mdio_t_nxt;
    end
  end

  // Command latch and read capture; rd_data only moves when a read completes.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_op_read <= 1'b0;
      r_hdr     <= 14'd0;
      r_wdata   <= 16'd0;
      r_rshift  <= 16'd0;
      r_rd_data <= 16'd0;
      r_rd_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_read <= op_read;
        r_hdr     <= {ST, (op_read ? OP_READ : OP_WRITE), phy_addr, reg_addr};
        r_wdata   <= wr_data;
        r_rd_err  <= 1'b0;
      end
      if (w_rise_stb && r_op_read) begin
        if (r_state == S_TA && r_cnt == 6'd1) r_rd_err <= mdio_i;
        if (r_state == S_DATA) r_rshift <= {r_rshift[14:0], mdio_i};
      end
      if (w_done_nxt && r_op_read) r_rd_data <= r_rshift;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_data = r_rd_data;
  assign rd_err  = r_rd_err;
  assign mdio_o  = r_mdio_o;
  assign mdio_t  = r_mdio_t;

endmodule

// File: tb/tb_sgmii_mdio_master.sv
// Bench for sgmii_mdio_master. Three instances cover CLK_DIV=2/PRE=32,
// CLK_DIV=3/PRE=32 (with a PHY model) and CLK_DIV=2/PRE=0. Stimulus pushes
// the expected frame into a scoreboard; a monitor records the MDIO line and
// tristate state at every mdc rise and checks the whole frame on done.
module tb_sgmii_mdio_master;

  typedef struct {
    int          inst;
    int          done_edge;
    int          nbits;
    logic [63:0] line;
    logic [63:0] tpat;
    logic [15:0] rd_data;
    logic        rd_err;
  } exp_t;

  int div_of [3] = '{2, 3, 2};
  int pre_of [3] = '{32, 32, 0};

  logic        ACLK = 1'b0;
  logic        rstn       [3];
  logic        start_s    [3];
  logic        op_read_s  [3];
  logic [4:0]  phy_s      [3];
  logic [4:0]  reg_s      [3];
  logic [15:0] wd_s       [3];
  logic        busy_s     [3];
  logic        done_s     [3];
  logic [15:0] rd_data_s  [3];
  logic        rd_err_s   [3];
  logic        mdc_s      [3];
  logic        mdio_o_s   [3];
  logic        mdio_t_s   [3];
  logic        mdio_i_s   [3];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb [$];

  logic [63:0] cap_line [3];
  logic [63:0] cap_t    [3];
  int          nrise    [3];
  logic        mdc_q    [3];

  logic        phy_present = 1'b1;
  logic [15:0] phy_val = 16'h0141;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // PHY on instance 1: released (pulled up) except TA2 low and the data word.
  function automatic logic phy_bit(input int r, input logic present, input logic [15:0] val);
    logic [3:0] idx;
    idx = 4'(63 - r);
    if (!present) return 1'b1;
    if (r == 47) return 1'b0;
    if (r >= 48 && r < 64) return val[idx];
    return 1'b1;
  endfunction

  assign mdio_i_s[0] = 1'b1;
  assign mdio_i_s[1] = phy_bit(nrise[1], phy_present, phy_val);
  assign mdio_i_s[2] = 1'b1;

  sgmii_mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_a (
    .ACLK(ACLK), .ARESETN(rstn[0]), .start(start_s[0]), .op_read(op_read_s[0]),
    .phy_addr(phy_s[0]), .reg_addr(reg_s[0]), .wr_data(wd_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .rd_data(rd_data_s[0]), .rd_err(rd_err_s[0]), .mdc(mdc_s[0]),
    .mdio_o(mdio_o_s[0]), .mdio_t(mdio_t_s[0]), .mdio_i(mdio_i_s[0]));

  sgmii_mdio_master #(.CLK_DIV(3), .PREAMBLE_LEN(32)) u_b (
    .ACLK(ACLK), .ARESETN(rstn[1]), .start(start_s[1]), .op_read(op_read_s[1]),
    .phy_addr(phy_s[1]), .reg_addr(reg_s[1]), .wr_data(wd_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .rd_data(rd_data_s[1]), .rd_err(rd_err_s[1]), .mdc(mdc_s[1]),
    .mdio_o(mdio_o_s[1]), .mdio_t(mdio_t_s[1]), .mdio_i(mdio_i_s[1]));

  sgmii_mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_c (
    .ACLK(ACLK), .ARESETN(rstn[2]), .start(start_s[2]), .op_read(op_read_s[2]),
    .phy_addr(phy_s[2]), .reg_addr(reg_s[2]), .wr_data(wd_s[2]), .busy(busy_s[2]),
    .done(done_s[2]), .rd_data(rd_data_s[2]), .rd_err(rd_err_s[2]), .mdc(mdc_s[2]),
    .mdio_o(mdio_o_s[2]), .mdio_t(mdio_t_s[2]), .mdio_i(mdio_i_s[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: capture line/tristate at each mdc rise, score the frame on done.
  always @(negedge ACLK) begin
    for (int i = 0; i < 3; i++) begin
      automatic logic line = mdio_t_s[i] ? mdio_i_s[i] : mdio_o_s[i];
      automatic exp_t e;
      if (mdc_s[i] === 1'b1 && mdc_q[i] !== 1'b1) begin
        cap_line[i] = {cap_line[i][62:0], line};
        cap_t[i]    = {cap_t[i][62:0], mdio_t_s[i]};
        nrise[i]++;
      end
      mdc_q[i] = mdc_s[i];
      if (done_s[i] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != i) begin
          n_checks++;
          n_fail++;
          $display("FAIL u%0d_spurious_done: got done=1 expected no done (edge %0d)", i, cyc);
        end else begin
          e = sb.pop_front();
          check($sformatf("u%0d_done_edge", i), 64'(cyc), 64'(e.done_edge));
          check($sformatf("u%0d_nbits", i), 64'(nrise[i]), 64'(e.nbits));
          check($sformatf("u%0d_line", i), cap_line[i], e.line);
          check($sformatf("u%0d_tristate", i), cap_t[i], e.tpat);
          check($sformatf("u%0d_rd_data", i), 64'(rd_data_s[i]), 64'(e.rd_data));
          check($sformatf("u%0d_rd_err", i), 64'(rd_err_s[i]), 64'(e.rd_err));
          check($sformatf("u%0d_end_mdc", i), 64'(mdc_s[i]), 64'd0);
          check($sformatf("u%0d_end_mdio_t", i), 64'(mdio_t_s[i]), 64'd1);
          check($sformatf("u%0d_end_mdio_o", i), 64'(mdio_o_s[i]), 64'd1);
          check($sformatf("u%0d_end_busy", i), 64'(busy_s[i]), 64'd0);
        end
      end
      if (busy_s[i] !== 1'b1) begin
        cap_line[i] = 64'd0;
        cap_t[i]    = 64'd0;
        nrise[i]    = 0;
      end
    end
  end

  // Issue one command; when expect_done is set the frame is scoreboarded.
  task automatic send(input int i, input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                      input logic [15:0] wd, input bit expect_done, input logic [63:0] line,
                      input logic [63:0] tpat, input logic [15:0] rdd, input logic rde);
    exp_t e;
    @(negedge ACLK);
    op_read_s[i] = rd;
    phy_s[i]     = pa;
    reg_s[i]     = ra;
    wd_s[i]      = wd;
    start_s[i]   = 1'b1;
    e.inst      = i;
    e.nbits     = pre_of[i] + 32;
    e.done_edge = cyc + 2 + e.nbits * 2 * div_of[i];
    e.line      = line;
    e.tpat      = tpat;
    e.rd_data   = rdd;
    e.rd_err    = rde;
    if (expect_done) sb.push_back(e);
    @(negedge ACLK);
    start_s[i] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge ACLK);
      k++;
    end
    @(negedge ACLK);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rises(input int i, input int n, input int budget);
    int k = 0;
    while (nrise[i] < n && k < budget) begin
      @(negedge ACLK);
      k++;
    end
    check($sformatf("u%0d_reach_bit%0d", i, n), 64'(nrise[i] >= n), 64'd1);
  endtask

  localparam logic [63:0] W_A = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00100, 2'b10, 16'hA5C3};
  localparam logic [63:0] R_B = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b11111, 5'b00010, 2'b10, 16'h0141};
  localparam logic [63:0] R_N = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00011, 5'b10001, 2'b11, 16'hFFFF};
  localparam logic [63:0] W_R = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00010, 5'b11010, 2'b10, 16'h3C96};
  localparam logic [63:0] W_C = {32'h0, 2'b01, 2'b01, 5'b10010, 5'b11011, 2'b10, 16'h5A0F};
  localparam logic [63:0] T_RD = 64'h0000_0000_0003_FFFF;

  initial begin
    int mdc_hi;
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; start_s[i] = 1'b0; op_read_s[i] = 1'b0;
      phy_s[i] = 5'd0; reg_s[i] = 5'd0; wd_s[i] = 16'd0;
      cap_line[i] = 64'd0; cap_t[i] = 64'd0; nrise[i] = 0; mdc_q[i] = 1'b0;
    end

    // Reset held for 5 cycles.
    repeat (5) @(negedge ACLK);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_rst_busy", i), 64'(busy_s[i]), 64'd0);
      check($sformatf("u%0d_rst_done", i), 64'(done_s[i]), 64'd0);
      check($sformatf("u%0d_rst_rd_data", i), 64'(rd_data_s[i]), 64'd0);
      check($sformatf("u%0d_rst_rd_err", i), 64'(rd_err_s[i]), 64'd0);
      check($sformatf("u%0d_rst_mdc", i), 64'(mdc_s[i]), 64'd0);
      check($sformatf("u%0d_rst_mdio_o", i), 64'(mdio_o_s[i]), 64'd1);
      check($sformatf("u%0d_rst_mdio_t", i), 64'(mdio_t_s[i]), 64'd1);
    end
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    mdc_hi = 0;
    repeat (100) begin
      @(negedge ACLK);
      for (int i = 0; i < 3; i++) if (mdc_s[i] !== 1'b0) mdc_hi++;
    end
    check("idle_mdc_high_cycles", 64'(mdc_hi), 64'd0);

    // Write, CLK_DIV=2, full preamble.
    send(0, 1'b0, 5'h01, 5'h04, 16'hA5C3, 1'b1, W_A, 64'd0, 16'h0000, 1'b0);
    drain(1000);

    // Same write with a conflicting start mid-header: must be ignored.
    send(0, 1'b0, 5'h01, 5'h04, 16'hA5C3, 1'b1, W_A, 64'd0, 16'h0000, 1'b0);
    wait_rises(0, 36, 500);
    send(0, 1'b1, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 64'd0, 64'd0, 16'h0000, 1'b0);
    check("u0_busy_after_ignored_start", 64'(busy_s[0]), 64'd1);
    drain(1000);

    // Read with PHY answering 0x0141, CLK_DIV=3.
    send(1, 1'b1, 5'h1F, 5'h02, 16'h0000, 1'b1, R_B, T_RD, 16'h0141, 1'b0);
    drain(1000);

    // Read with no PHY: all ones, turnaround error.
    phy_present = 1'b0;
    send(1, 1'b1, 5'h03, 5'h11, 16'h0000, 1'b1, R_N, T_RD, 16'hFFFF, 1'b1);
    drain(1000);

    // Read aborted by reset during DATA, then a normal write.
    send(0, 1'b1, 5'h05, 5'h06, 16'h0000, 1'b0, 64'd0, 64'd0, 16'h0000, 1'b0);
    wait_rises(0, 52, 1000);
    rstn[0] = 1'b0;
    @(negedge ACLK);
    check("abort_busy", 64'(busy_s[0]), 64'd0);
    check("abort_mdio_t", 64'(mdio_t_s[0]), 64'd1);
    check("abort_done", 64'(done_s[0]), 64'd0);
    check("abort_mdc", 64'(mdc_s[0]), 64'd0);
    check("abort_rd_data", 64'(rd_data_s[0]), 64'd0);
    rstn[0] = 1'b1;
    repeat (30) @(negedge ACLK);
    send(0, 1'b0, 5'h02, 5'h1A, 16'h3C96, 1'b1, W_R, 64'd0, 16'h0000, 1'b0);
    drain(1000);

    // No preamble: ST is the first bit.
    send(2, 1'b0, 5'h12, 5'h1B, 16'h5A0F, 1'b1, W_C, 64'd0, 16'h0000, 1'b0);
    drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
